// File: rtl/rx_frame_pkg.sv
// Shared types and helpers for the UART receive-frame shift register.
//   rx_state_t   : capture FSM states
//   cfg_ok()     : parameter range check used at elaboration
//   bit_reverse(): reverses the low n bits of a data field (MSB-first frames)
package rx_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rx_state_t;

  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_DATA_BITS = 9;
  localparam int MIN_STOP_BITS = 1;
  localparam int MAX_STOP_BITS = 2;

  function automatic bit cfg_ok(input int data_bits, input int parity_en,
                                input int parity_odd, input int stop_bits,
                                input int lsb_first);
    return (data_bits >= MIN_DATA_BITS) && (data_bits <= MAX_DATA_BITS) &&
           (stop_bits >= MIN_STOP_BITS) && (stop_bits <= MAX_STOP_BITS) &&
           (parity_en inside {0, 1}) && (parity_odd inside {0, 1}) &&
           (lsb_first inside {0, 1});
  endfunction

  // Bit i of the result takes bit n-1-i of v; bits at or above n are zero.
  function automatic logic [MAX_DATA_BITS-1:0] bit_reverse(
      input logic [MAX_DATA_BITS-1:0] v, input int n);
    logic [MAX_DATA_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      if (i < n) r[i] = v[n-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_frame_sr_shift_reg.sv
// frame_shift_reg: synchronous-reset right shift register with enable.
//   clk, rst   : clock, synchronous active-high reset
//   en         : shift this cycle
//   serial_in  : bit entering at the MSB
//   q          : register contents; the oldest bit ends up at q[0]
module frame_shift_reg #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= {serial_in, q[WIDTH-1:1]};
  end

endmodule

// File: rtl/rx_frame_sr.sv
// rx_frame_sr: captures one UART frame (data, optional parity, 1-2 stop bits)
// on shift_strobe after frame_start, then decodes and reports it.
//   clk, rst       : clock, synchronous active-high reset
//   frame_start    : start bit validated; (re)arms capture
//   shift_strobe   : sample serial_in this cycle
//   serial_in      : synchronised RX line
//   packet_data    : data of last completed frame, bit0 = first data LSB
//   stop_bit       : AND of received stop bits
//   parity_error   : parity mismatch (always 0 without parity)
//   framing_error  : some stop bit sampled 0
//   frame_done     : one-cycle pulse when the outputs above update
//   busy           : capture in progress (SHIFT or DONE)
module rx_frame_sr
  import rx_frame_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int LSB_FIRST  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 shift_strobe,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] packet_data,
  output logic                 stop_bit,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int FRAME_W = DATA_BITS + PARITY_EN + STOP_BITS;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  if (!cfg_ok(DATA_BITS, PARITY_EN, PARITY_ODD, STOP_BITS, LSB_FIRST)) begin : g_bad_cfg
    $error("rx_frame_sr: parameter out of range");
  end

  rx_state_t          state, state_next;
  logic [CNT_W-1:0]   count;
  logic [FRAME_W-1:0] sr;
  logic               sr_en, capture, last_bit;

  frame_shift_reg #(.WIDTH(FRAME_W)) u_sr (
    .clk       (clk),
    .rst       (rst),
    .en        (sr_en),
    .serial_in (serial_in),
    .q         (sr)
  );

  assign last_bit = (count == CNT_W'(FRAME_W - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (frame_start) state_next = SHIFT;
      SHIFT:   if (frame_start)                    state_next = SHIFT;
               else if (shift_strobe && last_bit)  state_next = DONE;
      DONE:    state_next = frame_start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs of the FSM; frame_start beats a coincident strobe.
  always_comb begin
    busy    = (state != IDLE);
    capture = (state == DONE);
    sr_en   = (state == SHIFT) && shift_strobe && !frame_start;
  end

  // Bit counter: cleared by frame_start, stops at FRAME_W once DONE is entered.
  always_ff @(posedge clk) begin
    if (rst)              count <= '0;
    else if (frame_start) count <= '0;
    else if (sr_en)       count <= count + 1'b1;
  end

  // Decode of the captured frame
  logic [DATA_BITS-1:0]     data_wire, data_dec;
  logic [MAX_DATA_BITS-1:0] data_wide;
  logic [STOP_BITS-1:0]     stop_field;
  logic                     par_bit, par_x, perr_dec;

  if (PARITY_EN != 0) begin : g_par
    assign par_bit = sr[DATA_BITS];
  end else begin : g_no_par
    assign par_bit = 1'b0;
  end

  always_comb begin
    data_wire              = sr[DATA_BITS-1:0];
    data_wide              = '0;
    data_wide[DATA_BITS-1:0] = data_wire;
    // MSB-first frames land with the MSB at bit0 and need flipping.
    data_dec   = (LSB_FIRST != 0) ? data_wire
                                  : DATA_BITS'(bit_reverse(data_wide, DATA_BITS));
    stop_field = sr[FRAME_W-1 -: STOP_BITS];
    par_x      = (^data_wire) ^ par_bit;
    perr_dec   = (PARITY_EN == 0) ? 1'b0 : ((PARITY_ODD != 0) ? ~par_x : par_x);
  end

  // Two-stage reporting: decode registered in DONE, published one edge later.
  logic [DATA_BITS-1:0] dec_data;
  logic                 dec_stop, dec_perr, dec_ferr, dec_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_data      <= '0;
      dec_stop      <= 1'b1;
      dec_perr      <= 1'b0;
      dec_ferr      <= 1'b0;
      dec_valid     <= 1'b0;
      packet_data   <= '0;
      stop_bit      <= 1'b1;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      dec_valid  <= capture;
      frame_done <= dec_valid;
      if (capture) begin
        dec_data <= data_dec;
        dec_stop <= &stop_field;
        dec_perr <= perr_dec;
        dec_ferr <= ~(&stop_field);
      end
      if (dec_valid) begin
        packet_data   <= dec_data;
        stop_bit      <= dec_stop;
        parity_error  <= dec_perr;
        framing_error <= dec_ferr;
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_sr.sv
// Self-checking bench for rx_frame_sr: default configuration plus a
// 7-bit / no parity / 2 stop / MSB-first instance.
module tb_rx_frame_sr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance
  logic       fs1 = 0, ss1 = 0, si1 = 1;
  logic [7:0] pd1;
  logic       sb1, pe1, fe1, fd1, bz1;

  rx_frame_sr u_dut1 (
    .clk(clk), .rst(rst), .frame_start(fs1), .shift_strobe(ss1), .serial_in(si1),
    .packet_data(pd1), .stop_bit(sb1), .parity_error(pe1), .framing_error(fe1),
    .frame_done(fd1), .busy(bz1)
  );

  // 7 data bits, no parity, 2 stop bits, MSB first
  logic       fs2 = 0, ss2 = 0, si2 = 1;
  logic [6:0] pd2;
  logic       sb2, pe2, fe2, fd2, bz2;

  rx_frame_sr #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2), .LSB_FIRST(0)) u_dut2 (
    .clk(clk), .rst(rst), .frame_start(fs2), .shift_strobe(ss2), .serial_in(si2),
    .packet_data(pd2), .stop_bit(sb2), .parity_error(pe2), .framing_error(fe2),
    .frame_done(fd2), .busy(bz2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  always @(posedge clk) if (fd1) done_cnt <= done_cnt + 1;

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_stop;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send n bits (bits[0] first) to one instance; one idle cycle between strobes.
  // Returns just after the edge that samples the final strobe.
  task automatic send_bits(input bit which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which) begin ss2 = 1; si2 = bits[i]; end
      else       begin ss1 = 1; si1 = bits[i]; end
      tick();
      ss1 = 0; ss2 = 0;
      if (i != n - 1) tick();
    end
  endtask

  task automatic start(input bit which);
    if (which) fs2 = 1; else fs1 = 1;
    tick();
    fs1 = 0; fs2 = 0;
  endtask

  logic [15:0] bits;
  logic [6:0]  d7;
  int          d0;

  initial begin
    vecs[0] = '{"a5_ok",      8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{"a5_bad",     8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{"3c_ok",      8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{"ff_ok",      8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{"01_badpar",  8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{"00_badpar",  8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{"80_ok",      8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1};

    // Reset held for two edges
    rst = 1;
    tick(); tick();
    check("rst_data",  32'(pd1), 32'h0);
    check("rst_stop",  32'(sb1), 32'h1);
    check("rst_perr",  32'(pe1), 32'h0);
    check("rst_ferr",  32'(fe1), 32'h0);
    check("rst_done",  32'(fd1), 32'h0);
    check("rst_busy",  32'(bz1), 32'h0);
    check("rst_data2", 32'(pd2), 32'h0);
    check("rst_stop2", 32'(sb2), 32'h1);
    rst = 0;
    tick();

    // Table-driven frames on the default instance
    foreach (vecs[k]) begin
      d0 = done_cnt;
      start(0);
      check({vecs[k].name, "_busy"}, 32'(bz1), 32'h1);
      send_bits(0, {6'b0, vecs[k].stop, vecs[k].par, vecs[k].data}, 10);
      check({vecs[k].name, "_done_e0"}, 32'(fd1), 32'h0);
      tick();
      check({vecs[k].name, "_done_e1"}, 32'(fd1), 32'h0);
      tick();
      check({vecs[k].name, "_done_e2"}, 32'(fd1), 32'h1);
      check({vecs[k].name, "_data"},    32'(pd1), 32'(vecs[k].exp_data));
      check({vecs[k].name, "_perr"},    32'(pe1), 32'(vecs[k].exp_perr));
      check({vecs[k].name, "_ferr"},    32'(fe1), 32'(vecs[k].exp_ferr));
      check({vecs[k].name, "_stop"},    32'(sb1), 32'(vecs[k].exp_stop));
      tick();
      check({vecs[k].name, "_done_e3"}, 32'(fd1), 32'h0);
      check({vecs[k].name, "_pulses"},  32'(done_cnt - d0), 32'h1);
    end

    // Outputs hold between frames
    repeat (5) tick();
    check("hold_data", 32'(pd1), 32'h80);

    // Restart mid-frame, with a strobe coinciding with the restart
    d0 = done_cnt;
    start(0);
    send_bits(0, 16'h000F, 4);
    fs1 = 1; ss1 = 1; si1 = 1;
    tick();
    fs1 = 0; ss1 = 0;
    send_bits(0, {6'b0, 1'b1, 1'b0, 8'h3C}, 10);
    tick(); tick();
    check("restart_done", 32'(fd1), 32'h1);
    check("restart_data", 32'(pd1), 32'h3C);
    check("restart_perr", 32'(pe1), 32'h0);
    tick();
    check("restart_pulses", 32'(done_cnt - d0), 32'h1);

    // frame_start during DONE: report still issued, new capture begins
    d0 = done_cnt;
    start(0);
    send_bits(0, {6'b0, 1'b1, 1'b0, 8'hA5}, 10);
    fs1 = 1;
    tick();
    fs1 = 0;
    check("done_start_busy", 32'(bz1), 32'h1);
    tick();
    check("done_start_done", 32'(fd1), 32'h1);
    check("done_start_data", 32'(pd1), 32'hA5);
    send_bits(0, {6'b0, 1'b1, 1'b1, 8'h5A}, 10);
    tick(); tick();
    check("chain_data", 32'(pd1), 32'h5A);
    check("chain_perr", 32'(pe1), 32'h1);
    tick();
    check("chain_pulses", 32'(done_cnt - d0), 32'h2);

    // Reset mid-frame, then strobes with no frame_start
    start(0);
    send_bits(0, 16'h001F, 5);
    rst = 1;
    tick();
    rst = 0;
    check("abort_data", 32'(pd1), 32'h0);
    check("abort_stop", 32'(sb1), 32'h1);
    check("abort_busy", 32'(bz1), 32'h0);
    d0 = done_cnt;
    send_bits(0, 16'hFFFF, 16);
    send_bits(0, 16'h000F, 4);
    repeat (5) tick();
    check("orphan_pulses", 32'(done_cnt - d0), 32'h0);
    check("orphan_busy",   32'(bz1), 32'h0);
    check("orphan_data",   32'(pd1), 32'h0);

    // 7-bit MSB-first instance: 7'h55 with stops 1,0, then 7'h0B with stops 1,1
    d7 = 7'h55;
    bits = '0;
    for (int i = 0; i < 7; i++) bits[i] = d7[6-i];
    bits[7] = 1'b1; bits[8] = 1'b0;
    start(1);
    send_bits(1, bits, 9);
    tick();
    check("m55_done_e1", 32'(fd2), 32'h0);
    tick();
    check("m55_done", 32'(fd2), 32'h1);
    check("m55_data", 32'(pd2), 32'h55);
    check("m55_stop", 32'(sb2), 32'h0);
    check("m55_ferr", 32'(fe2), 32'h1);
    check("m55_perr", 32'(pe2), 32'h0);

    d7 = 7'h0B;
    bits = '0;
    for (int i = 0; i < 7; i++) bits[i] = d7[6-i];
    bits[7] = 1'b1; bits[8] = 1'b1;
    start(1);
    send_bits(1, bits, 9);
    tick(); tick();
    check("m0b_done", 32'(fd2), 32'h1);
    check("m0b_data", 32'(pd2), 32'h0B);
    check("m0b_stop", 32'(sb2), 32'h1);
    check("m0b_ferr", 32'(fe2), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
